// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the external memory port arbiter and any other bus master
// that wants to describe a memory request as a single packed word.
package mem_bus_arbiter_pkg;

  localparam int MEM_ADDR_W = 24;
  localparam int MEM_DATA_W = 16;
  localparam int CNT_W      = 4;

  typedef enum logic {
    OWN_IFETCH = 1'b0,
    OWN_DMEM   = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-pin bundle of the arbiter; slave is the arbiter's view,
// master is the view of whatever drives the requests and models the memory.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              ifetch_req_i;
  logic [ADDR_W-1:0] ifetch_addr_i;
  logic              ifetch_ack_o;
  logic [DATA_W-1:0] ifetch_data_o;

  logic              dmem_req_i;
  logic              dmem_we_i;
  logic [ADDR_W-1:0] dmem_addr_i;
  logic [DATA_W-1:0] dmem_wdata_i;
  logic              dmem_ack_o;
  logic [DATA_W-1:0] dmem_rdata_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_re_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              busy_o;

  modport slave (
    input  ifetch_req_i, ifetch_addr_i,
    input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
    input  mem_data_i,
    output ifetch_ack_o, ifetch_data_o,
    output dmem_ack_o, dmem_rdata_o,
    output mem_addr_o, mem_re_o, mem_we_o, mem_data_o, busy_o
  );

  modport master (
    output ifetch_req_i, ifetch_addr_i,
    output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
    output mem_data_i,
    input  ifetch_ack_o, ifetch_data_o,
    input  dmem_ack_o, dmem_rdata_o,
    input  mem_addr_o, mem_re_o, mem_we_o, mem_data_o, busy_o
  );
endinterface

// File: rtl/mem_arb_priority.sv
// Combinational grant selection: data side wins unless fetch is contending and
// the data side has already taken MAX_DATA_STREAK contested grants in a row.
module mem_arb_priority
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic             ifetch_req,
  input  logic             dmem_req,
  input  logic [CNT_W-1:0] streak,
  output logic             grant_valid,
  output owner_e           owner
);

  logic fetch_forced;

  always_comb begin
    fetch_forced = ifetch_req && (streak == CNT_W'(MAX_DATA_STREAK));
    grant_valid  = ifetch_req || dmem_req;
    owner        = OWN_IFETCH;
    if (dmem_req && !fetch_forced) begin
      owner = OWN_DMEM;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the external memory port; one access at a time.
// Request seen in IDLE -> strobes for WAIT_STATES+1 cycles -> ack; losers simply stay pending.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W          = MEM_ADDR_W,
  parameter int DATA_W          = MEM_DATA_W,
  parameter int WAIT_STATES     = 0,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] streak_q;
  mem_req_t         req_q;
  owner_e           owner_q;

  logic             grant_valid;
  owner_e           grant_owner;
  logic             grant_en;
  logic             done_en;
  logic             contested;
  mem_req_t         grant_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  mem_arb_priority #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_priority (
    .ifetch_req  (bus.ifetch_req_i),
    .dmem_req    (bus.dmem_req_i),
    .streak      (streak_q),
    .grant_valid (grant_valid),
    .owner       (grant_owner)
  );

  assign contested = bus.ifetch_req_i && bus.dmem_req_i;

  // Fetch is read-only, so its latched request never carries write data.
  always_comb begin
    sel_addr  = bus.ifetch_addr_i;
    sel_we    = 1'b0;
    sel_wdata = '0;
    if (grant_owner == OWN_DMEM) begin
      sel_addr  = bus.dmem_addr_i;
      sel_we    = bus.dmem_we_i;
      sel_wdata = bus.dmem_wdata_i;
    end
    grant_req = '{addr: sel_addr, we: sel_we, wdata: sel_wdata};
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    done_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_en = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          done_en = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      streak_q <= '0;
      req_q    <= '0;
      owner_q  <= OWN_IFETCH;
    end else begin
      if (grant_en) begin
        cnt_q   <= CNT_W'(WAIT_STATES);
        req_q   <= grant_req;
        owner_q <= grant_owner;
        if (grant_owner == OWN_IFETCH) begin
          streak_q <= '0;
        end else if (contested) begin
          streak_q <= streak_q + CNT_W'(1);
        end
      end else if (state_q == ST_ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Strobes, acks and read data are flops so reset clears them without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_re_o      <= 1'b0;
      bus.mem_we_o      <= 1'b0;
      bus.ifetch_ack_o  <= 1'b0;
      bus.dmem_ack_o    <= 1'b0;
      bus.ifetch_data_o <= '0;
      bus.dmem_rdata_o  <= '0;
      bus.busy_o        <= 1'b0;
    end else begin
      if (grant_en) begin
        bus.mem_re_o <= ~grant_req.we;
        bus.mem_we_o <= grant_req.we;
      end else if (done_en) begin
        bus.mem_re_o <= 1'b0;
        bus.mem_we_o <= 1'b0;
      end
      bus.ifetch_ack_o <= done_en && (owner_q == OWN_IFETCH);
      bus.dmem_ack_o   <= done_en && (owner_q == OWN_DMEM);
      if (done_en && !req_q.we) begin
        if (owner_q == OWN_IFETCH) begin
          bus.ifetch_data_o <= bus.mem_data_i;
        end else begin
          bus.dmem_rdata_o  <= bus.mem_data_i;
        end
      end
      bus.busy_o <= (state_d != ST_IDLE);
    end
  end

  assign bus.mem_addr_o = req_q.addr;
  assign bus.mem_data_o = req_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: two arbiter instances (0 and 3 wait states) share stimulus;
// sel picks which one is observed. Expected acks are queued per requester.
module tb_mem_bus_arbiter;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic        ifetch_req = 1'b0;
  logic [23:0] ifetch_addr = '0;
  logic        dmem_req = 1'b0;
  logic        dmem_we = 1'b0;
  logic [23:0] dmem_addr = '0;
  logic [15:0] dmem_wdata = '0;

  logic [15:0] last_ifd = '0;
  logic [15:0] last_drd = '0;
  exp_t q_if[$];
  exp_t q_dm[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_f(input logic [23:0] a);
    if (a == 24'h000100) return 16'hBEEF;
    if (a == 24'h000200) return 16'h00FF;
    return a[15:0] ^ 16'hA5C3;
  endfunction

  mem_bus_arbiter_if #(.ADDR_W(24), .DATA_W(16)) if0 ();
  mem_bus_arbiter_if #(.ADDR_W(24), .DATA_W(16)) if3 ();

  assign if0.ifetch_req_i  = ifetch_req;
  assign if0.ifetch_addr_i = ifetch_addr;
  assign if0.dmem_req_i    = dmem_req;
  assign if0.dmem_we_i     = dmem_we;
  assign if0.dmem_addr_i   = dmem_addr;
  assign if0.dmem_wdata_i  = dmem_wdata;
  assign if0.mem_data_i    = mem_f(if0.mem_addr_o);
  assign if3.ifetch_req_i  = ifetch_req;
  assign if3.ifetch_addr_i = ifetch_addr;
  assign if3.dmem_req_i    = dmem_req;
  assign if3.dmem_we_i     = dmem_we;
  assign if3.dmem_addr_i   = dmem_addr;
  assign if3.dmem_wdata_i  = dmem_wdata;
  assign if3.mem_data_i    = mem_f(if3.mem_addr_o);

  mem_bus_arbiter #(.ADDR_W(24), .DATA_W(16), .WAIT_STATES(WS0), .MAX_DATA_STREAK(4)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  mem_bus_arbiter #(.ADDR_W(24), .DATA_W(16), .WAIT_STATES(WS1), .MAX_DATA_STREAK(4)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  wire        s_if_ack  = sel ? if3.ifetch_ack_o  : if0.ifetch_ack_o;
  wire [15:0] s_if_data = sel ? if3.ifetch_data_o : if0.ifetch_data_o;
  wire        s_dm_ack  = sel ? if3.dmem_ack_o    : if0.dmem_ack_o;
  wire [15:0] s_dm_data = sel ? if3.dmem_rdata_o  : if0.dmem_rdata_o;
  wire [23:0] s_addr    = sel ? if3.mem_addr_o    : if0.mem_addr_o;
  wire [15:0] s_wdata   = sel ? if3.mem_data_o    : if0.mem_data_o;
  wire        s_re      = sel ? if3.mem_re_o      : if0.mem_re_o;
  wire        s_we      = sel ? if3.mem_we_o      : if0.mem_we_o;
  wire        s_busy    = sel ? if3.busy_o        : if0.busy_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest expectation of its requester.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (s_if_ack && s_dm_ack) chk("ack_overlap", 1, 0);
      if (s_re && s_we) chk("strobe_overlap", 1, 0);
      if (s_if_ack) begin
        if (q_if.size() == 0) chk("if_spurious_ack", 1, 0);
        else begin
          e = q_if.pop_front();
          chk("if_ack_cyc", cyc, e.cyc);
          chk("if_data", {16'h0, s_if_data}, {16'h0, e.data});
          last_ifd = e.data;
        end
      end
      if (s_dm_ack) begin
        if (q_dm.size() == 0) chk("dm_spurious_ack", 1, 0);
        else begin
          e = q_dm.pop_front();
          chk("dm_ack_cyc", cyc, e.cyc);
          chk("dm_rdata", {16'h0, s_dm_data}, {16'h0, e.data});
          last_drd = e.data;
        end
      end
    end
  end

  task automatic to_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_ack(input bit is_dm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (is_dm ? s_dm_ack : s_if_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic req_if(input logic [23:0] a, input int exp_cyc);
    exp_t e;
    bit ok;
    e.data = mem_f(a);
    e.cyc  = exp_cyc;
    q_if.push_back(e);
    ifetch_addr = a;
    ifetch_req  = 1'b1;
    wait_ack(1'b0, ok);
    if (!ok) chk("if_ack_timeout", 0, 1);
    @(posedge clk);
    #1 ifetch_req = 1'b0;
  endtask

  task automatic req_dm(input logic we, input logic [23:0] a, input logic [15:0] wd,
                        input int exp_cyc, input bit keep);
    exp_t e;
    bit ok;
    e.data = we ? last_drd : mem_f(a);
    e.cyc  = exp_cyc;
    q_dm.push_back(e);
    dmem_we    = we;
    dmem_addr  = a;
    dmem_wdata = wd;
    dmem_req   = 1'b1;
    wait_ack(1'b1, ok);
    if (!ok) chk("dm_ack_timeout", 0, 1);
    @(posedge clk);
    #1 if (!keep) dmem_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifetch_req = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    #3;
    chk("rst_strobes", {s_re, s_we, s_busy, s_if_ack, s_dm_ack}, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_wdata", s_wdata, 0);
    chk("rst_if_data", s_if_data, 0);
    chk("rst_dm_data", s_dm_data, 0);
    q_if.delete();
    q_dm.delete();
    last_ifd = '0;
    last_drd = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    int p;

    // ---------- zero wait states ----------
    sel = 1'b0;
    do_reset();

    @(posedge clk); #1 t0 = cyc;
    fork
      req_if(24'h000100, t0 + WS0 + 2);
      begin
        to_neg(t0 + 1);
        chk("f_re_c1", s_re, 1);
        chk("f_busy_c1", s_busy, 1);
        chk("f_addr_c1", s_addr, 24'h000100);
        to_neg(t0 + 2);
        chk("f_re_c2", s_re, 0);
        chk("f_busy_c2", s_busy, 1);
        to_neg(t0 + 3);
        chk("f_busy_c3", s_busy, 0);
      end
    join

    p = WS0 + 3;
    @(posedge clk); #1 t0 = cyc;
    fork
      req_dm(1'b0, 24'h000400, 16'h0, t0 + WS0 + 2, 1'b0);
      req_if(24'h000500, t0 + p + WS0 + 2);
    join

    // Data requester hammers the bus; fetch must get through after 4 contested grants.
    @(posedge clk); #1 t0 = cyc;
    fork
      begin
        for (int k = 0; k < 4; k++)
          req_dm(1'b0, 24'h001000 + 24'(k), 16'h0, t0 + k * p + WS0 + 2, 1'b1);
        req_dm(1'b0, 24'h002000, 16'h0, t0 + 5 * p + WS0 + 2, 1'b0);
      end
      req_if(24'h003000, t0 + 4 * p + WS0 + 2);
    join
    chk("streak_cleared", {28'h0, u_dut0.streak_q}, 0);

    // ---------- three wait states ----------
    sel = 1'b1;
    do_reset();

    @(posedge clk); #1 t0 = cyc;
    req_if(24'h000100, t0 + WS1 + 2);
    @(posedge clk); #1 t0 = cyc;
    req_dm(1'b0, 24'h000200, 16'h0, t0 + WS1 + 2, 1'b0);
    chk("if_data_hold", {16'h0, s_if_data}, {16'h0, last_ifd});

    @(posedge clk); #1 t0 = cyc;
    fork
      req_dm(1'b1, 24'h00ABCD, 16'h1234, t0 + WS1 + 2, 1'b0);
      begin
        for (int c = 1; c <= WS1 + 1; c++) begin
          to_neg(t0 + c);
          chk("w_we", s_we, 1);
          chk("w_re", s_re, 0);
          chk("w_addr", s_addr, 24'h00ABCD);
          chk("w_data", s_wdata, 16'h1234);
        end
        to_neg(t0 + WS1 + 2);
        chk("w_we_done", s_we, 0);
      end
    join
    chk("drd_hold_after_wr", s_dm_data, 16'h00FF);

    // Reset in the middle of an access: strobes drop with no clock edge, no ack.
    @(posedge clk); #1 t0 = cyc;
    dmem_we   = 1'b0;
    dmem_addr = 24'h000300;
    dmem_req  = 1'b1;
    to_neg(t0 + 2);
    chk("pre_rst_re", s_re, 1);
    chk("pre_rst_busy", s_busy, 1);
    #2 rst_n = 1'b0;
    dmem_req = 1'b0;
    #1;
    chk("arst_re", s_re, 0);
    chk("arst_busy", s_busy, 0);
    last_drd = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_ack_post_rst", {s_dm_ack, s_if_ack}, 0);
    end
    @(posedge clk); #1 t0 = cyc;
    req_dm(1'b0, 24'h000300, 16'h0, t0 + WS1 + 2, 1'b0);

    repeat (4) @(posedge clk);
    chk("if_queue_empty", q_if.size(), 0);
    chk("dm_queue_empty", q_dm.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory port (24-bit address, 16-bit data, re/we strobes) between two requesters: instruction fetch (read-only) and the memory pipeline stage (read/write).
- Sequences each transaction through a programmable number of wait states and returns an ack pulse with captured read data.
- Sits between the fetch/mem stages and the top-level memory pins. Requester stall logic is built from req and ack.

Parameters:
- ADDR_W, 24, memory address width.
- DATA_W, 16, memory data width.
- WAIT_STATES, 0, extra cycles each access holds the bus before data is sampled (0..15).
- MAX_DATA_STREAK, 4, consecutive contested data grants allowed before fetch is forced through (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifetch_req_i  in  1  fetch request; held until ifetch_ack_o.
- ifetch_addr_i  in  ADDR_W  fetch word address.
- ifetch_ack_o  out  1  one-cycle completion pulse.
- ifetch_data_o  out  DATA_W  fetched word; valid with ack, held afterwards.
- dmem_req_i  in  1  data request; held until dmem_ack_o.
- dmem_we_i  in  1  1 = write, 0 = read.
- dmem_addr_i  in  ADDR_W  data address.
- dmem_wdata_i  in  DATA_W  write data.
- dmem_ack_o  out  1  one-cycle completion pulse.
- dmem_rdata_o  out  DATA_W  read data; updated only on read completion, held otherwise.
- mem_addr_o  out  ADDR_W  memory address.
- mem_re_o  out  1  memory read strobe.
- mem_we_o  out  1  memory write strobe.
- mem_data_o  out  DATA_W  memory write data.
- mem_data_i  in  DATA_W  memory read data.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, wait counter 0, streak counter 0. Mid-transaction reset drops mem_re_o/mem_we_o immediately (async) and issues no ack.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: if any request is pending, select a winner, latch its addr/we/wdata and owner id, load wait counter = WAIT_STATES, and go to ACCESS. With no request, stay in IDLE.
- Arbitration: dmem wins over ifetch, except when both request and streak == MAX_DATA_STREAK, in which case ifetch wins.
  - A contested dmem grant increments streak.
  - Any ifetch grant clears streak.
  - An uncontested dmem grant leaves streak unchanged.
- ACCESS: mem_addr_o/mem_data_o are driven from the latched values.
  - mem_re_o = ~latched_we; mem_we_o = latched_we. Both are stable for all WAIT_STATES+1 cycles.
  - Counter decrements each cycle. When the counter is 0, capture mem_data_i (reads only) into the owner's data output, deassert strobes, and go to DONE.
- DONE: owner's ack = 1 for exactly this cycle. No grant is made. Next state is IDLE.
- Latency: req seen in IDLE at cycle 0 → strobes cycles 1..1+WAIT_STATES → ack at cycle 2+WAIT_STATES. Bus occupancy is WAIT_STATES+3 cycles per transaction.
- Requester rule: req may drop or change on the cycle after ack. Inputs changing during ACCESS have no effect because they are latched.
- Simultaneous requests in IDLE: exactly one grant. The loser stays pending and is granted in the next IDLE.
- Request deasserted before grant: ignored, no ack.
- Writes: ifetch never writes. dmem write ack leaves dmem_rdata_o unchanged.
- Strobes are never both high. Ack pulses are never both high.

Decomposition:
- Shared package contents:
  - owner enum {OWN_IFETCH, OWN_DMEM}.
  - state enum {ST_IDLE, ST_ACCESS, ST_DONE}.
  - mem_req_t struct {addr, we, wdata}, reusable by other bus masters.
- One natural sub-module: mem_arb_priority. It is combinational and takes both reqs and streak as inputs, producing grant_valid and owner, so the fairness policy can be tested alone. The FSM, counters and data capture stay in the top module.

Test Plan:
- Single fetch, WAIT_STATES=0: ifetch_req, addr 0x000100, mem_data_i=0xBEEF → mem_re_o high cycle 1 only; ifetch_ack_o and ifetch_data_o=0xBEEF at cycle 2; busy_o cycles 1–2.
- Data write, WAIT_STATES=2: dmem write 0x1234 to 0x00ABCD → mem_we_o high cycles 1–3 with stable addr/data; dmem_ack_o at cycle 4; dmem_rdata_o unchanged.
- Contention: both req at cycle 0 → dmem granted first (ack cycle 2), ifetch granted next IDLE (ack cycle 5); acks never overlap.
- Starvation guard, MAX_DATA_STREAK=4: dmem re-requests continuously while ifetch is held → exactly 4 dmem acks, then the ifetch ack, then streak resets to 0.
- Async reset asserted mid-ACCESS (WAIT_STATES=3, cycle 2) → strobes and busy_o drop without a clock edge; no ack. After release, a re-issued request completes normally.
- Read-data hold: dmem read returns 0x00FF, then a dmem write completes → dmem_rdata_o stays 0x00FF; ifetch_data_o is unaffected by dmem reads.
